axi_ready_sched: RTL
====================

AXI_READY_SCHED -- requirements
Module: axi_ready_sched

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, the non-zero seed loaded into the random-policy LFSR on reset.
REQ-002 SHALL have parameter MAX_LOW, default 16, the maximum consecutive ready-low cycles in RANDOM policy.
REQ-003 SHALL have port aclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cfg_load, input, 1 bit: single-cycle pulse that latches all cfg_* inputs.
REQ-006 SHALL have port cfg_policy, input, 2 bits: 0 NO_BACKPRESSURE, 1 OSC, 2 SINGLE_LOW, 3 RANDOM.
REQ-007 SHALL have port cfg_high_time, input, 8 bits: high-phase length in OSC.
REQ-008 SHALL have port cfg_low_time, input, 8 bits: low-phase length in OSC and SINGLE_LOW.
REQ-009 SHALL have port cfg_prob, input, 8 bits: ready threshold in RANDOM.
REQ-010 SHALL have port valid, input, 1 bit: the VALID of the AXI channel being paced.
REQ-011 SHALL have port ready, output, 1 bit: registered READY driven onto the channel.
REQ-012 SHALL have port xfer_cnt, output, 16 bits: count of handshakes (valid && ready).
REQ-013 SHALL have port policy_active, output, 2 bits: the currently latched policy.

Function
REQ-014 SHALL latch the cfg_* inputs at the rising edge where cfg_load=1, clear the phase counter and the watchdog, and apply the new policy to ready from the next cycle; cfg_* SHALL be ignored while cfg_load=0.
REQ-015 NO_BACKPRESSURE SHALL hold ready=1 every cycle.
REQ-016 OSC SHALL start with a high phase after load; ready SHALL be 1 for H cycles, then 0 for cfg_low_time cycles, repeating independently of valid; H=max(cfg_high_time,1); cfg_low_time=0 SHALL give ready=1 constantly.
REQ-017 SHALL_LOW (SINGLE_LOW) SHALL hold ready=1 until a handshake; a handshake in cycle t SHALL give ready=0 in cycles t+1..t+cfg_low_time and ready=1 in cycle t+cfg_low_time+1; cfg_low_time=0 SHALL give ready=1 constantly.
REQ-018 RANDOM SHALL advance a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) every cycle; next ready SHALL be 1 when the next LFSR[7:0] <= cfg_prob, so cfg_prob=255 gives ready=1 constantly.
REQ-019 RANDOM SHALL force ready=1 for one cycle after MAX_LOW consecutive ready=0 cycles, then reset the watchdog count.
REQ-020 ready SHALL be a registered output whose next value depends only on the current state, the latched config and the current cycle's valid and ready; no combinational path from valid to ready.
REQ-021 xfer_cnt SHALL increment by 1 on each cycle with valid && ready, SHALL saturate at 16'hFFFF, and SHALL NOT be cleared by cfg_load.
REQ-022 A cfg_load coincident with a handshake SHALL count the handshake; the new policy SHALL govern ready from the next cycle and SHALL NOT start a SINGLE_LOW low phase for that handshake.

Reset
REQ-023 While reset=1: ready=0, xfer_cnt=0, policy_active=NO_BACKPRESSURE, phase counter=0, watchdog=0, LFSR=LFSR_SEED; latched high/low/prob=0.
REQ-024 ready SHALL be 1 in the first cycle after reset deasserts; reset mid-phase SHALL abandon the phase with no residual low cycles.

Structure
REQ-025 Shared package axi_ready_pkg SHALL hold enum ready_policy_t, the LFSR taps constant and the default MAX_LOW.
REQ-026 The LFSR SHALL be sub-module axi_ready_lfsr (ports aclk, reset, seed, advance, value); all other logic SHALL be in axi_ready_sched.

Verification
REQ-027 Reset held 5 cycles -> ready=0 throughout; first cycle after reset ready=1, xfer_cnt=0, policy_active=0.
REQ-028 OSC, cfg_high_time=2, cfg_low_time=3, valid=1 for 20 cycles -> ready pattern 1,1,0,0,0 repeated 4 times; xfer_cnt=8.
REQ-029 SINGLE_LOW, cfg_low_time=2, valid held 1 for 9 cycles -> ready 1,0,0 repeated 3 times; xfer_cnt=3.
REQ-030 RANDOM, cfg_prob=0, 1000 cycles -> no run of ready=0 longer than 16 cycles; ready=1 at least 1000/17 times.
REQ-031 Load OSC (H=1, L=10), then load NO_BACKPRESSURE in the 3rd low cycle -> ready=1 from the cycle after the load; handshake count unaffected.
REQ-032 Preload path with xfer_cnt=16'hFFFE, NO_BACKPRESSURE, valid=1 for 3 cycles -> xfer_cnt reads FFFF and stays there; then assert reset mid-OSC low phase -> xfer_cnt=0, ready=1 the cycle after reset.

Source files
------------

// File: rtl/axi_ready_pkg.sv
// Shared types and constants for the AXI READY back-pressure scheduler.
package axi_ready_pkg;

  typedef enum logic [1:0] {
    POL_NO_BACKPRESSURE = 2'd0,
    POL_OSC             = 2'd1,
    POL_SINGLE_LOW      = 2'd2,
    POL_RANDOM          = 2'd3
  } ready_policy_t;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 for a right-shifting register
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;
  localparam int unsigned DEFAULT_MAX_LOW = 16;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/axi_ready_lfsr.sv
// 16-bit Galois LFSR, seeded on reset and stepped when advance is high.
module axi_ready_lfsr
  import axi_ready_pkg::*;
(
  input  logic        aclk,
  input  logic        reset,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = value_q;
    if (advance) value_d = lfsr_step(value_q);
  end

  always_ff @(posedge aclk) begin
    if (reset) value_q <= seed;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/axi_ready_sched.sv
// Registered READY generator with selectable back-pressure policies and a
// saturating handshake counter.
module axi_ready_sched
  import axi_ready_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_LOW   = DEFAULT_MAX_LOW
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        cfg_load,
  input  logic [1:0]  cfg_policy,
  input  logic [7:0]  cfg_high_time,
  input  logic [7:0]  cfg_low_time,
  input  logic [7:0]  cfg_prob,
  input  logic        valid,
  output logic        ready,
  output logic [15:0] xfer_cnt,
  output logic [1:0]  policy_active
);

  localparam logic [16:0] MAX_LOW_W = 17'(MAX_LOW);

  ready_policy_t policy_q, policy_d;
  logic [7:0]    high_q, high_d;
  logic [7:0]    low_q, low_d;
  logic [7:0]    prob_q, prob_d;
  logic [7:0]    phase_q, phase_d;
  logic [15:0]   wdog_q, wdog_d;
  logic [15:0]   xfer_q, xfer_d;
  logic          ready_q, ready_d;

  logic          hs;
  logic [7:0]    high_eff;
  logic [8:0]    phase_inc;
  logic [16:0]   wdog_inc;
  logic          low_done;
  logic          rnd_hit;
  logic [15:0]   lfsr_val;
  logic          lfsr_adv;

  axi_ready_lfsr u_lfsr (
    .aclk    (aclk),
    .reset   (reset),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  always_comb begin
    hs        = valid && ready_q;
    high_eff  = (high_q == '0) ? 8'd1 : high_q;
    phase_inc = {1'b0, phase_q} + 9'd1;
    wdog_inc  = {1'b0, wdog_q} + 17'd1;
    low_done  = phase_inc >= {1'b0, low_q};
    // Threshold is applied to the LFSR value that will be current next cycle
    rnd_hit   = (lfsr_step(lfsr_val) & 16'h00FF) <= {8'h00, (cfg_load ? cfg_prob : prob_q)};

    xfer_d   = (hs && (xfer_q != '1)) ? xfer_q + 16'd1 : xfer_q;
    policy_d = policy_q;
    high_d   = high_q;
    low_d    = low_q;
    prob_d   = prob_q;
    phase_d  = phase_q;
    wdog_d   = '0;
    ready_d  = 1'b1;

    if (cfg_load) begin
      policy_d = ready_policy_t'(cfg_policy);
      high_d   = cfg_high_time;
      low_d    = cfg_low_time;
      prob_d   = cfg_prob;
      phase_d  = '0;
      ready_d  = (policy_d == POL_RANDOM) ? rnd_hit : 1'b1;
    end else begin
      unique case (policy_q)
        POL_NO_BACKPRESSURE: ready_d = 1'b1;
        POL_OSC: begin
          if (low_q == '0) begin
            phase_d = '0;
          end else if (ready_q) begin
            if (phase_inc >= {1'b0, high_eff}) begin
              ready_d = 1'b0;
              phase_d = '0;
            end else begin
              phase_d = phase_inc[7:0];
            end
          end else if (low_done) begin
            phase_d = '0;
          end else begin
            ready_d = 1'b0;
            phase_d = phase_inc[7:0];
          end
        end
        POL_SINGLE_LOW: begin
          if (ready_q) begin
            if (hs && (low_q != '0)) begin
              ready_d = 1'b0;
              phase_d = '0;
            end
          end else if (low_done) begin
            phase_d = '0;
          end else begin
            ready_d = 1'b0;
            phase_d = phase_inc[7:0];
          end
        end
        POL_RANDOM: begin
          // wdog_q holds the low cycles already completed before this one
          ready_d = rnd_hit || (!ready_q && (wdog_inc >= MAX_LOW_W));
          wdog_d  = (ready_d || ready_q) ? '0 : wdog_inc[15:0];
        end
        default: ready_d = 1'b1;
      endcase
    end
  end

  assign lfsr_adv = (policy_d == POL_RANDOM);

  always_ff @(posedge aclk) begin
    if (reset) begin
      policy_q <= POL_NO_BACKPRESSURE;
      high_q   <= '0;
      low_q    <= '0;
      prob_q   <= '0;
      phase_q  <= '0;
      wdog_q   <= '0;
      xfer_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      policy_q <= policy_d;
      high_q   <= high_d;
      low_q    <= low_d;
      prob_q   <= prob_d;
      phase_q  <= phase_d;
      wdog_q   <= wdog_d;
      xfer_q   <= xfer_d;
      ready_q  <= ready_d;
    end
  end

  assign ready         = ready_q;
  assign xfer_cnt      = xfer_q;
  assign policy_active = policy_q;

endmodule
